// File: rtl/puf_pkg.sv
// Shared definitions for the serial PUF response path.
//   PUF_CNT_W       : default counter width, shared with post_mux_counter
//   puf_state_e     : collector sequencing states
//   puf_count_width : width needed to hold the values 0..max_val
package puf_pkg;

  localparam int PUF_CNT_W = 7;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    COUNT,
    COMPARE,
    SHIFT,
    DONE
  } puf_state_e;

  function automatic int puf_count_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/puf_resp_serializer.sv
// Parallel-load response register with a valid/ready serial output.
// The word is shifted out LSB first, one bit per accepted handshake.
// Ports:
//   clk, reset   : clock, asynchronous active-low reset
//   load         : capture load_data and start presenting bit 0
//   load_data    : N_BITS response word
//   resp_ready   : downstream accepts resp_bit this cycle
//   resp_bit     : current response bit (0 when not valid)
//   resp_valid   : resp_bit is valid
//   last_accept  : the final bit is being accepted this cycle
module puf_resp_serializer #(
  parameter int N_BITS = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [N_BITS-1:0] load_data,
  input  logic              resp_ready,
  output logic              resp_bit,
  output logic              resp_valid,
  output logic              last_accept
);

  localparam int PTR_W = $clog2(N_BITS);

  logic [N_BITS-1:0] shift_reg;
  logic [N_BITS-1:0] shift_next;
  logic [PTR_W-1:0]  ptr_reg;
  logic              valid_reg;
  logic              accept;

  assign accept      = valid_reg & resp_ready;
  assign last_accept = accept & (ptr_reg == PTR_W'(N_BITS - 1));

  // Shift toward bit 0 so the bit under the pointer is always shift_reg[0].
  genvar gi;
  generate
    for (gi = 0; gi < N_BITS - 1; gi++) begin : g_shift
      assign shift_next[gi] = shift_reg[gi+1];
    end
  endgenerate
  assign shift_next[N_BITS-1] = 1'b0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_reg <= '0;
      ptr_reg   <= '0;
      valid_reg <= 1'b0;
    end else if (load) begin
      shift_reg <= load_data;
      ptr_reg   <= '0;
      valid_reg <= 1'b1;
    end else if (accept) begin
      shift_reg <= shift_next;
      ptr_reg   <= ptr_reg + PTR_W'(1);
      if (last_accept) begin
        valid_reg <= 1'b0;
      end
    end
  end

  // Held stable during a stall because nothing moves without accept.
  assign resp_bit   = valid_reg & shift_reg[0];
  assign resp_valid = valid_reg;

endmodule

// File: rtl/puf_response_collector.sv
// Sequences a pair of post_mux_counter instances over N_BITS challenges,
// turns each count pair into one response bit (count_a > count_b), then
// streams the response word out serially LSB first.
// Ports:
//   clk, reset                : clock, asynchronous active-low reset
//   start                     : begin a run (only honoured when idle)
//   count_a/count_b           : counter values
//   finished_a/finished_b     : counter done levels
//   cnt_enable, cnt_clear     : counter controls
//   challenge_idx             : current challenge (upstream mux select)
//   resp_bit/valid/ready      : serial response handshake
//   busy, done, error         : run status; error is sticky until next start
//   tie_count                 : equal-count comparisons in this run
module puf_response_collector
  import puf_pkg::*;
#(
  parameter int CNT_W   = PUF_CNT_W,
  parameter int N_BITS  = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [CNT_W-1:0]          count_a,
  input  logic [CNT_W-1:0]          count_b,
  input  logic                      finished_a,
  input  logic                      finished_b,
  output logic                      cnt_enable,
  output logic                      cnt_clear,
  output logic [$clog2(N_BITS)-1:0] challenge_idx,
  output logic                      resp_bit,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic                      busy,
  output logic                      done,
  output logic                      error,
  output logic [$clog2(N_BITS):0]   tie_count
);

  localparam int IDX_W = $clog2(N_BITS);
  localparam int WD_W  = puf_count_width(TIMEOUT);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BITS - 1);
  localparam logic [IDX_W:0]   TIE_MAX  = (IDX_W + 1)'(N_BITS);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);

  puf_state_e        state_reg;
  puf_state_e        state_next;
  logic [IDX_W-1:0]  idx_reg;
  logic [IDX_W:0]    tie_reg;
  logic              error_reg;
  logic              fin_a_seen_reg;
  logic              fin_b_seen_reg;
  logic [WD_W-1:0]   wdog_reg;
  logic [N_BITS-1:0] resp_reg;
  logic [N_BITS-1:0] resp_next;

  logic start_accept;
  logic both_seen;
  logic timeout_hit;
  logic last_idx;
  logic a_gt_b;
  logic a_eq_b;
  logic in_compare;
  logic ser_load;
  logic ser_last_accept;

  assign start_accept = (state_reg == IDLE) && start;
  assign in_compare   = (state_reg == COMPARE);
  assign last_idx     = (idx_reg == LAST_IDX);
  assign a_gt_b       = (count_a > count_b);
  assign a_eq_b       = (count_a == count_b);
  assign timeout_hit  = (wdog_reg == WD_LAST);
  // Include this cycle's flags so a flag seen on the same cycle as its
  // partner's earlier one moves on without an extra COUNT cycle.
  assign both_seen    = (fin_a_seen_reg | finished_a) & (fin_b_seen_reg | finished_b);

  // The bit landing in COMPARE is folded in combinationally so the
  // serializer can be loaded with the complete word on the same edge.
  assign ser_load = in_compare && last_idx;

  genvar gi;
  generate
    for (gi = 0; gi < N_BITS; gi++) begin : g_resp
      assign resp_next[gi] = start_accept ? 1'b0 :
                             (in_compare && (idx_reg == IDX_W'(gi))) ? a_gt_b :
                             resp_reg[gi];
    end
  endgenerate

  // Next-state and decoded outputs.
  always_comb begin
    state_next = state_reg;
    cnt_enable = 1'b0;
    cnt_clear  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = CLEAR;
        end
      end
      CLEAR: begin
        cnt_clear  = 1'b1;
        busy       = 1'b1;
        state_next = COUNT;
      end
      COUNT: begin
        cnt_enable = 1'b1;
        busy       = 1'b1;
        if (both_seen) begin
          state_next = COMPARE;
        end else if (timeout_hit) begin
          state_next = DONE;
        end
      end
      COMPARE: begin
        busy       = 1'b1;
        state_next = last_idx ? SHIFT : CLEAR;
      end
      SHIFT: begin
        busy = 1'b1;
        if (ser_last_accept) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      idx_reg        <= '0;
      tie_reg        <= '0;
      error_reg      <= 1'b0;
      fin_a_seen_reg <= 1'b0;
      fin_b_seen_reg <= 1'b0;
      wdog_reg       <= '0;
      resp_reg       <= '0;
    end else begin
      state_reg <= state_next;
      resp_reg  <= resp_next;

      if (start_accept) begin
        idx_reg   <= '0;
        tie_reg   <= '0;
        error_reg <= 1'b0;
      end

      if (state_reg == CLEAR) begin
        fin_a_seen_reg <= 1'b0;
        fin_b_seen_reg <= 1'b0;
        wdog_reg       <= '0;
      end

      if (state_reg == COUNT) begin
        fin_a_seen_reg <= fin_a_seen_reg | finished_a;
        fin_b_seen_reg <= fin_b_seen_reg | finished_b;
        wdog_reg       <= wdog_reg + WD_W'(1);
        if (!both_seen && timeout_hit) begin
          error_reg <= 1'b1;
        end
      end

      if (in_compare) begin
        if (a_eq_b && (tie_reg != TIE_MAX)) begin
          tie_reg <= tie_reg + (IDX_W + 1)'(1);
        end
        // Index stays on the last challenge through SHIFT and DONE.
        if (!last_idx) begin
          idx_reg <= idx_reg + IDX_W'(1);
        end
      end
    end
  end

  puf_resp_serializer #(
    .N_BITS(N_BITS)
  ) u_serializer (
    .clk        (clk),
    .reset      (reset),
    .load       (ser_load),
    .load_data  (resp_next),
    .resp_ready (resp_ready),
    .resp_bit   (resp_bit),
    .resp_valid (resp_valid),
    .last_accept(ser_last_accept)
  );

  assign challenge_idx = idx_reg;
  assign error         = error_reg;
  assign tie_count     = tie_reg;

endmodule

// File: tb/tb_puf_response_collector.sv
// Self-checking bench for puf_response_collector (N_BITS=4, CNT_W=7,
// TIMEOUT=20). A negedge process models the counter pair and the
// downstream receiver; the initial block runs table vectors, hand-written
// sequences and randomized runs checked against a behavioural model.
module tb_puf_response_collector;

  localparam int N_BITS  = 4;
  localparam int CNT_W   = 7;
  localparam int TIMEOUT = 20;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [CNT_W-1:0] count_a = '0;
  logic [CNT_W-1:0] count_b = '0;
  logic             finished_a = 1'b0;
  logic             finished_b = 1'b0;
  logic             resp_ready = 1'b0;
  logic             cnt_enable;
  logic             cnt_clear;
  logic [1:0]       challenge_idx;
  logic             resp_bit;
  logic             resp_valid;
  logic             busy;
  logic             done;
  logic             error;
  logic [2:0]       tie_count;

  puf_response_collector #(
    .CNT_W  (CNT_W),
    .N_BITS (N_BITS),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .count_a      (count_a),
    .count_b      (count_b),
    .finished_a   (finished_a),
    .finished_b   (finished_b),
    .cnt_enable   (cnt_enable),
    .cnt_clear    (cnt_clear),
    .challenge_idx(challenge_idx),
    .resp_bit     (resp_bit),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .tie_count    (tie_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // ---------------- per-run configuration (written by initial only) -----
  int cfg_a[N_BITS];
  int cfg_b[N_BITS];
  int cfg_fa[N_BITS];     // COUNT cycle where finished_a first rises, 0 = never
  int cfg_fb[N_BITS];
  bit cfg_pulse[N_BITS];  // finished_a is a one-cycle pulse instead of a level
  int cfg_stall_bit = -1;
  int cfg_stall_len = 0;
  bit rand_ready = 1'b0;
  int run_id = 0;

  // ---------------- monitor statistics (written by monitor only) --------
  int         seen_run = 0;
  int         k = 0;
  logic [7:0] rx_word;
  int         rx_n;
  int         valid_cnt;
  int         done_cnt;
  int         clear_cnt[N_BITS];
  int         cyc_cnt[N_BITS];
  int         stall_viol;
  int         stall_left;
  int         idx_q[$];
  bit         prev_stalled;
  logic       prev_bit;
  bit         rdy;

  // Counter pair + receiver model. Inputs for the coming posedge are
  // driven here, and outputs are observed away from the active edge.
  always @(negedge clk) begin
    if (run_id != seen_run) begin
      seen_run     = run_id;
      rx_word      = '0;
      rx_n         = 0;
      valid_cnt    = 0;
      done_cnt     = 0;
      stall_viol   = 0;
      stall_left   = cfg_stall_len;
      prev_stalled = 1'b0;
      prev_bit     = 1'b0;
      idx_q.delete();
      for (int i = 0; i < N_BITS; i++) begin
        clear_cnt[i] = 0;
        cyc_cnt[i]   = 0;
      end
    end

    if (cnt_clear) begin
      k = 0;
      clear_cnt[challenge_idx]++;
      idx_q.push_back(int'(challenge_idx));
    end
    if (cnt_enable) begin
      k++;
      cyc_cnt[challenge_idx]++;
      finished_a = (cfg_fa[challenge_idx] != 0) &&
                   (cfg_pulse[challenge_idx] ? (k == cfg_fa[challenge_idx])
                                             : (k >= cfg_fa[challenge_idx]));
      finished_b = (cfg_fb[challenge_idx] != 0) && (k >= cfg_fb[challenge_idx]);
    end else begin
      finished_a = 1'b0;
      finished_b = 1'b0;
    end
    count_a = cfg_a[challenge_idx][CNT_W-1:0];
    count_b = cfg_b[challenge_idx][CNT_W-1:0];

    if (rand_ready) begin
      rdy = ($urandom_range(0, 2) != 0);
    end else begin
      rdy = !(resp_valid && (rx_n == cfg_stall_bit) && (stall_left > 0));
      if (!rdy) stall_left--;
    end
    resp_ready = rdy;

    if (prev_stalled && (!resp_valid || (resp_bit != prev_bit))) stall_viol++;
    prev_stalled = resp_valid && !rdy;
    prev_bit     = resp_bit;

    if (resp_valid) valid_cnt++;
    if (resp_valid && rdy && (rx_n < 8)) begin
      rx_word[rx_n] = resp_bit;
      rx_n++;
    end
    if (done) done_cnt++;
  end

  // ---------------- behavioural reference model -------------------------
  logic [3:0] m_word;
  int         m_ties;
  bit         m_err;
  int         m_nb;
  int         m_neval;
  int         m_cyc[N_BITS];

  // A challenge completes on the later of the two first-flag cycles,
  // provided it lies within the TIMEOUT-cycle window; otherwise the run
  // aborts there with no serial output.
  function automatic void model();
    int kb;
    m_word  = '0;
    m_ties  = 0;
    m_err   = 1'b0;
    m_neval = 0;
    for (int i = 0; i < N_BITS; i++) m_cyc[i] = 0;
    for (int i = 0; i < N_BITS; i++) begin
      if (m_err) continue;
      m_neval = i + 1;
      if (cfg_fa[i] == 0 || cfg_fb[i] == 0) kb = TIMEOUT + 1;
      else kb = (cfg_fa[i] > cfg_fb[i]) ? cfg_fa[i] : cfg_fb[i];
      if (kb > TIMEOUT) begin
        m_cyc[i] = TIMEOUT;
        m_err    = 1'b1;
      end else begin
        m_cyc[i] = kb;
        if (cfg_a[i] > cfg_b[i]) m_word[i] = 1'b1;
        else if (cfg_a[i] == cfg_b[i]) m_ties++;
      end
    end
    m_nb = m_err ? 0 : N_BITS;
  endfunction

  // ---------------- vector table -------------------------------------
  typedef struct packed {
    logic [3:0][6:0] a;
    logic [3:0][6:0] b;
    logic [3:0][6:0] fa;
    logic [3:0][6:0] fb;
    logic [3:0]      pulse;
    int              stall_bit;
    int              stall_len;
    logic [3:0]      exp_word;
    int              exp_ties;
    bit              exp_err;
    int              exp_nb;
  } vec_t;

  localparam int N_VEC = 7;
  vec_t  tbl[N_VEC];
  string tbl_name[N_VEC];

  function automatic logic [3:0][6:0] q4(input int x0, input int x1, input int x2, input int x3);
    logic [3:0][6:0] r;
    r[0] = x0[6:0];
    r[1] = x1[6:0];
    r[2] = x2[6:0];
    r[3] = x3[6:0];
    return r;
  endfunction

  task automatic load_vec(input vec_t v);
    for (int i = 0; i < N_BITS; i++) begin
      cfg_a[i]     = int'(v.a[i]);
      cfg_b[i]     = int'(v.b[i]);
      cfg_fa[i]    = int'(v.fa[i]);
      cfg_fb[i]    = int'(v.fb[i]);
      cfg_pulse[i] = v.pulse[i];
    end
    cfg_stall_bit = v.stall_bit;
    cfg_stall_len = v.stall_len;
  endtask

  task automatic wait_done(input string nm, input int budget);
    bit seen = 1'b0;
    for (int w = 0; w < budget && !seen; w++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) chk({nm, ":done_timeout"}, 0, 1);
  endtask

  // One complete run with start pulsed for a single cycle.
  task automatic do_run(input string nm, input logic [3:0] ew, input int et,
                        input bit ee, input int enb);
    model();
    run_id++;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({nm, ":first_clear"}, int'(cnt_clear), 1);
    chk({nm, ":error_cleared"}, int'(error), 0);
    chk({nm, ":ties_cleared"}, int'(tie_count), 0);
    chk({nm, ":idx_start"}, int'(challenge_idx), 0);
    wait_done(nm, 600);
    @(negedge clk);
    chk({nm, ":busy_after"}, int'(busy), 0);
    chk({nm, ":done_width"}, int'(done), 0);
    chk({nm, ":valid_after"}, int'(resp_valid), 0);
    chk({nm, ":error"}, int'(error), int'(ee));
    chk({nm, ":ties"}, int'(tie_count), et);
    chk({nm, ":bits_rx"}, rx_n, enb);
    if (enb > 0) chk({nm, ":word"}, int'(rx_word[3:0]), int'(ew));
    else chk({nm, ":valid_cycles"}, valid_cnt, 0);
    chk({nm, ":done_pulses"}, done_cnt, 1);
    chk({nm, ":stall_stable"}, stall_viol, 0);
    chk({nm, ":challenges"}, idx_q.size(), m_neval);
    for (int i = 0; i < m_neval && i < idx_q.size(); i++) begin
      chk($sformatf("%s:idx_order%0d", nm, i), idx_q[i], i);
      chk($sformatf("%s:clears%0d", nm, i), clear_cnt[i], 1);
      chk($sformatf("%s:count_cycles%0d", nm, i), cyc_cnt[i], m_cyc[i]);
    end
    $display("run %-10s word=%b ties=%0d err=%0d bits=%0d", nm, rx_word[3:0],
             tie_count, error, rx_n);
  endtask

  initial begin
    bit reached;

    tbl[0] = '{a: q4(50, 30, 77, 100), b: q4(40, 60, 77, 1), fa: q4(5, 5, 5, 5),
               fb: q4(5, 5, 5, 5), pulse: 4'b0000, stall_bit: -1, stall_len: 0,
               exp_word: 4'b1001, exp_ties: 1, exp_err: 1'b0, exp_nb: 4};
    tbl_name[0] = "basic";
    tbl[1] = tbl[0];
    tbl[1].stall_bit = 1;
    tbl[1].stall_len = 3;
    tbl_name[1] = "stall_b1";
    tbl[2] = tbl[0];
    tbl[2].fb = q4(5, 5, 0, 5);
    tbl[2].exp_word = 4'b0000;
    tbl[2].exp_ties = 0;
    tbl[2].exp_err  = 1'b1;
    tbl[2].exp_nb   = 0;
    tbl_name[2] = "tmo_c2";
    tbl[3] = '{a: q4(5, 5, 9, 0), b: q4(5, 6, 3, 0), fa: q4(2, 2, 2, 2),
               fb: q4(6, 6, 6, 6), pulse: 4'b1111, stall_bit: -1, stall_len: 0,
               exp_word: 4'b0100, exp_ties: 2, exp_err: 1'b0, exp_nb: 4};
    tbl_name[3] = "pulse_a";
    tbl[4] = '{a: q4(10, 0, 127, 3), b: q4(10, 0, 127, 3), fa: q4(1, 20, 1, 20),
               fb: q4(20, 1, 20, 20), pulse: 4'b0000, stall_bit: -1, stall_len: 0,
               exp_word: 4'b0000, exp_ties: 4, exp_err: 1'b0, exp_nb: 4};
    tbl_name[4] = "tie_edge";
    tbl[5] = tbl[0];
    tbl[5].fa = q4(0, 5, 5, 5);
    tbl[5].fb = q4(1, 5, 5, 5);
    tbl[5].exp_word = 4'b0000;
    tbl[5].exp_ties = 0;
    tbl[5].exp_err  = 1'b1;
    tbl[5].exp_nb   = 0;
    tbl_name[5] = "tmo_c0";
    tbl[6] = '{a: q4(127, 0, 1, 126), b: q4(0, 127, 0, 127), fa: q4(1, 1, 3, 3),
               fb: q4(1, 1, 1, 1), pulse: 4'b0000, stall_bit: 3, stall_len: 2,
               exp_word: 4'b0101, exp_ties: 0, exp_err: 1'b0, exp_nb: 4};
    tbl_name[6] = "extremes";

    load_vec(tbl[0]);

    // Power-on reset.
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("por:busy", int'(busy), 0);
    chk("por:done", int'(done), 0);
    chk("por:cnt_enable", int'(cnt_enable), 0);
    chk("por:cnt_clear", int'(cnt_clear), 0);
    chk("por:resp_valid", int'(resp_valid), 0);
    chk("por:error", int'(error), 0);
    chk("por:tie_count", int'(tie_count), 0);
    chk("por:idx", int'(challenge_idx), 0);
    reset = 1'b1;
    @(negedge clk);
    chk("idle:ignore_none", int'(busy), 0);

    // Reset in the middle of COUNT abandons the run without a done pulse.
    run_id++;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    reached = 1'b0;
    for (int w = 0; w < 200 && !reached; w++) begin
      @(negedge clk);
      if (cnt_enable && challenge_idx == 2'd1) reached = 1'b1;
    end
    chk("rst_mid:reached", int'(reached), 1);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid:busy", int'(busy), 0);
    chk("rst_mid:cnt_enable", int'(cnt_enable), 0);
    chk("rst_mid:resp_valid", int'(resp_valid), 0);
    chk("rst_mid:idx", int'(challenge_idx), 0);
    @(negedge clk);
    chk("rst_mid:no_done", done_cnt, 0);
    reset = 1'b1;
    @(negedge clk);

    // Table-driven vectors.
    rand_ready = 1'b0;
    for (int v = 0; v < N_VEC; v++) begin
      load_vec(tbl[v]);
      do_run(tbl_name[v], tbl[v].exp_word, tbl[v].exp_ties, tbl[v].exp_err,
             tbl[v].exp_nb);
    end

    // start held high: back-to-back runs separated by one idle cycle.
    load_vec(tbl[0]);
    run_id++;
    @(negedge clk);
    start = 1'b1;
    wait_done("hold1", 600);
    @(negedge clk);
    chk("hold:idle_gap_busy", int'(busy), 0);
    chk("hold:idle_gap_clear", int'(cnt_clear), 0);
    @(negedge clk);
    chk("hold:relaunch", int'(cnt_clear), 1);
    start = 1'b0;
    wait_done("hold2", 600);
    @(negedge clk);
    chk("hold:bits_rx", rx_n, 8);
    chk("hold:words", int'(rx_word), 8'h99);
    chk("hold:done_pulses", done_cnt, 2);
    chk("hold:busy_after", int'(busy), 0);
    $display("run %-10s words=%h done=%0d", "hold", rx_word, done_cnt);

    // Randomized runs against the model.
    rand_ready = 1'b1;
    cfg_stall_bit = -1;
    cfg_stall_len = 0;
    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < N_BITS; i++) begin
        cfg_a[i]     = $urandom_range(0, 1) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 127));
        cfg_b[i]     = $urandom_range(0, 1) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 127));
        cfg_fa[i]    = ($urandom_range(0, 19) == 0) ? 0 : int'($urandom_range(1, 21));
        cfg_fb[i]    = ($urandom_range(0, 19) == 0) ? 0 : int'($urandom_range(1, 21));
        cfg_pulse[i] = $urandom_range(0, 1);
      end
      model();
      do_run($sformatf("rand%0d", r), m_word, m_ties, m_err, m_nb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
